brcomp_iter: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle branch comparator.
- Compares two DATA_W-bit operands CHUNK_W bits per cycle, MSB chunk first, to trade latency for area.
- Decodes the full RISC-V branch funct3 set and returns less, equal, taken and illegal flags.
- Sits between operand read and PC-select in the multi-cycle core; valid/ready on both sides.

---
 rtl/brcomp_pkg.sv | 43 ++++
 rtl/brcomp_chunk.sv | 22 ++
 rtl/brcomp_iter.sv | 119 +++++++++++
 tb/tb_brcomp_iter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/brcomp_pkg.sv
// Shared types and funct3 decode helpers for the iterative branch comparator.
package brcomp_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_RSV2 = 3'b010,
        BR_RSV3 = 3'b011,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } brcomp_state_e;

    // Reserved 01x encodings fall back to a signed compare.
    function automatic logic decode_unsigned(input br_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_illegal(input br_op_e op);
        return op[2:1] == 2'b01;
    endfunction

    function automatic logic decode_taken(input br_op_e op, input logic less, input logic equal);
        logic t;
        t = 1'b0;
        case (op)
            BR_BEQ:           t = equal;
            BR_BNE:           t = !equal;
            BR_BLT, BR_BLTU:  t = less;
            BR_BGE, BR_BGEU:  t = !less;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/brcomp_chunk.sv
// One CHUNK_W-bit magnitude comparator; flip_msb maps two's complement to offset binary.
module brcomp_chunk #(
    parameter int unsigned CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               flip_msb,
    output logic               lt,
    output logic               eq
);

    localparam logic [CHUNK_W-1:0] MSB_MASK = CHUNK_W'(1) << (CHUNK_W - 1);

    logic [CHUNK_W-1:0] a_m;
    logic [CHUNK_W-1:0] b_m;

    assign a_m = flip_msb ? (a ^ MSB_MASK) : a;
    assign b_m = flip_msb ? (b ^ MSB_MASK) : b;
    assign lt  = a_m < b_m;
    assign eq  = a_m == b_m;

endmodule

// File: rtl/brcomp_iter.sv
// Multi-cycle RISC-V branch comparator, MSB chunk first.
// Define BRCOMP_EARLY_EXIT_EN to finish on the first differing chunk.
module brcomp_iter
    import brcomp_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CHUNK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [2:0]        br_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              br_less,
    output logic              br_equal,
    output logic              br_taken,
    output logic              br_illegal
);

    localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    if ((CHUNK_W == 0) || (DATA_W % CHUNK_W != 0)) begin : g_bad_width
        $error("brcomp_iter: DATA_W must be a nonzero multiple of CHUNK_W");
    end

    brcomp_state_e     state;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    br_op_e            op_q;
    logic [IDX_W-1:0]  idx;
    logic              decided;
    logic              lt_q;

    logic c_lt, c_eq, flip, differ, dec_nx, lt_nx, finish;

    // Operands shift left each CMP cycle so the live chunk is always the top one.
    assign flip = !decode_unsigned(op_q) && (idx == IDX_TOP);

    brcomp_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
        .a        (a_q[DATA_W-1 -: CHUNK_W]),
        .b        (b_q[DATA_W-1 -: CHUNK_W]),
        .flip_msb (flip),
        .lt       (c_lt),
        .eq       (c_eq)
    );

    assign differ = !c_eq;
    assign dec_nx = decided | differ;
    assign lt_nx  = decided ? lt_q : c_lt;

`ifdef BRCOMP_EARLY_EXIT_EN
    assign finish = (idx == '0) || differ;
`else
    assign finish = (idx == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            br_less    <= 1'b0;
            br_equal   <= 1'b0;
            br_taken   <= 1'b0;
            br_illegal <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= BR_BEQ;
            idx        <= '0;
            decided    <= 1'b0;
            lt_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= rs1_data;
                        b_q      <= rs2_data;
                        op_q     <= br_op_e'(br_op);
                        idx      <= IDX_TOP;
                        decided  <= 1'b0;
                        lt_q     <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    decided <= dec_nx;
                    lt_q    <= lt_nx;
                    idx     <= idx - IDX_W'(1);
                    a_q     <= a_q << CHUNK_W;
                    b_q     <= b_q << CHUNK_W;
                    if (finish) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        br_less    <= lt_nx;
                        br_equal   <= !dec_nx;
                        br_taken   <= decode_taken(op_q, lt_nx, !dec_nx);
                        br_illegal <= is_illegal(op_q);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brcomp_iter.sv
// Scoreboard bench for brcomp_iter; latency expectations follow BRCOMP_EARLY_EXIT_EN.
module tb_brcomp_iter;
    import brcomp_pkg::*;

    localparam int DATA_W  = 32;
    localparam int CHUNK_W = 8;
    localparam int NCHUNK  = DATA_W / CHUNK_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [2:0]        br_op;
    logic              out_valid;
    logic              out_ready;
    logic              br_less, br_equal, br_taken, br_illegal;

    typedef struct {
        logic less;
        logic equal;
        logic taken;
        logic illegal;
        int   lat;
        int   acc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   seen        = 1'b0;
    int   lat_obs     = 0;

    brcomp_iter #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .br_op      (br_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .br_less    (br_less),
        .br_equal   (br_equal),
        .br_taken   (br_taken),
        .br_illegal (br_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference result plus cycle count from accept to first out_valid.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input int acc);
        exp_t e;
        logic uns;
        int   k;
        uns       = (op == 3'b110) || (op == 3'b111);
        e.less    = uns ? (a < b) : ($signed(a) < $signed(b));
        e.equal   = (a == b);
        e.illegal = (op == 3'b010) || (op == 3'b011);
        case (op)
            3'b000:         e.taken = e.equal;
            3'b001:         e.taken = !e.equal;
            3'b100, 3'b110: e.taken = e.less;
            3'b101, 3'b111: e.taken = !e.less;
            default:        e.taken = 1'b0;
        endcase
        k = NCHUNK;
`ifdef BRCOMP_EARLY_EXIT_EN
        begin
            logic [31:0] x;
            bit found;
            x = a ^ b;
            found = 1'b0;
            for (int i = 0; i < NCHUNK; i++) begin
                if (!found && x[31:24] != 8'h00) begin
                    k = i + 1;
                    found = 1'b1;
                end
                x = x << 8;
            end
        end
`endif
        e.lat = k + 1;
        e.acc = acc;
        return e;
    endfunction

    // Caller is positioned 1 time unit after a rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input bit expect_out);
        int n = 0;
        rs1_data = a;
        rs2_data = b;
        br_op    = op;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("accept", 32'(in_ready), 32'd1);
        if (expect_out) sb.push_back(model(a, b, op, cyc));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out", 32'(sb.size()), 32'd1);
            end else begin
                if (!seen) begin
                    seen    = 1'b1;
                    lat_obs = cyc - sb[0].acc;
                end
                if (out_ready) begin
                    e = sb.pop_front();
                    check_eq("less",    32'(br_less),    32'(e.less));
                    check_eq("equal",   32'(br_equal),   32'(e.equal));
                    check_eq("taken",   32'(br_taken),   32'(e.taken));
                    check_eq("illegal", 32'(br_illegal), 32'(e.illegal));
                    check_eq("latency", 32'(lat_obs),    32'(e.lat));
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [31:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rs1_data  = '0;
        rs2_data  = '0;
        br_op     = 3'b000;
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_flags", 32'({out_valid, br_less, br_equal, br_taken, br_illegal}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Sign versus unsigned interpretation of an all-ones operand
        issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1); drain();
        issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b1); drain();
        // Equal operands take the full chunk count
        issue(32'h1234_5678, 32'h1234_5678, 3'b000, 1'b1); drain();
        issue(32'h1234_5678, 32'h1234_5678, 3'b001, 1'b1); drain();
        // Signed extremes decided on the MSB chunk
        issue(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b1); drain();
        // Difference only in the LSB chunk
        issue(32'h0000_0100, 32'h0000_0101, 3'b110, 1'b1); drain();

        // Backpressure: result must hold and new requests be ignored
        out_ready = 1'b0;
        issue(32'h0000_0005, 32'h0000_0009, 3'b100, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        br_op    = 3'b000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold", 32'({out_valid, br_less, br_equal, br_taken, br_illegal}), 32'b11010);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_drop", 32'(out_valid), 32'd0);
        check_eq("bp_ready_back", 32'(in_ready), 32'd1);
        check_eq("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during the second compare cycle discards the operation
        issue(32'h0000_0001, 32'h0000_0002, 3'b100, 1'b0);
        @(posedge clk); #1;
        check_eq("pre_rst_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_flags", 32'({out_valid, br_less, br_equal, br_taken, br_illegal}), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        issue(32'h0000_0010, 32'h0000_0010, 3'b010, 1'b1); drain();
        issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b011, 1'b1); drain();

        // Mixed random operations, half with shared upper chunks
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? {ra[31:8], 8'($urandom)} : $urandom;
            issue(ra, rb, 3'($urandom_range(0, 7)), 1'b1);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
